// File: rtl/instruction_fetch.sv
// Instruction fetch unit for the RV32I core.
// Keeps the program counter, issues word addresses to a synchronous-read
// instruction memory, and queues returned words in a 2-entry buffer that
// decode drains through a valid/ready handshake. A redirect from execute
// flushes everything in flight and restarts fetch at the target.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          MEM_ADDR_WIDTH = 5
) (
  input  logic                      fetch_clk,
  input  logic                      fetch_rst,
  output logic [MEM_ADDR_WIDTH-1:0] fetch_mem_addr,
  input  logic [31:0]               fetch_mem_data,
  output logic [31:0]               fetch_instr,
  output logic [31:0]               fetch_pc,
  output logic                      fetch_valid,
  input  logic                      fetch_ready,
  input  logic                      fetch_redirect,
  input  logic [31:0]               fetch_redirect_pc,
  output logic                      fetch_misalign
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic [31:0] pc_q;
  logic        inflight_q;
  logic [31:0] inflight_pc_q;
  logic        misalign_q;

  // Buffer: head_q is always the oldest entry, tail_q the younger one.
  entry_t      head_q;
  entry_t      tail_q;
  logic [1:0]  count_q;

  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occupancy;
  entry_t      new_entry;

  assign fetch_mem_addr = pc_q[MEM_ADDR_WIDTH+1:2];
  assign fetch_valid    = (count_q != 2'd0);
  assign fetch_instr    = head_q.instr;
  assign fetch_pc       = head_q.pc;
  assign fetch_misalign = misalign_q;

  // Handshake, return and issue decisions for the current cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pop       = 1'b0;
    push      = 1'b0;
    issue     = 1'b0;
    occupancy = 3'd0;
    new_entry = '{instr: fetch_mem_data, pc: inflight_pc_q};

    pop  = fetch_valid && fetch_ready;
    // A word returning during a redirect cycle is dropped with the flush.
    push = inflight_q && !fetch_redirect;
    // Slots already claimed after this edge; pop implies count >= 1, so no underflow.
    occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    // Issue only when the word coming back next cycle is guaranteed a slot.
    issue = !fetch_rst && !fetch_redirect && (occupancy <= 3'd1);
  end

  // Program counter, in-flight tracking and the misalignment pulse.
  always_ff @(posedge fetch_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (fetch_rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      misalign_q    <= 1'b0;
    end else begin
      misalign_q <= fetch_redirect && (fetch_redirect_pc[1:0] != 2'b00);
      if (fetch_redirect) begin
        pc_q       <= {fetch_redirect_pc[31:2], 2'b00};
        inflight_q <= 1'b0;
      end else if (issue) begin
        inflight_q    <= 1'b1;
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + 32'd4;
      end else begin
        inflight_q <= 1'b0;
      end
    end
  end

  // Two-entry ordered buffer between memory return and decode.
  always_ff @(posedge fetch_clk) begin
    if (fetch_rst) begin
      // NOTE: the payload registers are reset too, so the head outputs read zero out of reset.
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else if (fetch_redirect) begin
      count_q <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q <= new_entry;
          end else begin
            head_q <= tail_q;
            tail_q <= new_entry;
          end
        end
        2'b10: begin
          if (count_q == 2'd0) head_q <= new_entry;
          else                 tail_q <= new_entry;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch. Stimulus queues the instructions
// decode should receive; a monitor pops and compares on each handshake.
module tb_instruction_fetch;

  localparam int AW = 5;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_data;
  logic [31:0]   instr;
  logic [31:0]   fpc;
  logic          valid;
  logic          ready;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          misalign;

  logic [31:0]   mem [32];
  exp_t          sb [$];
  exp_t          mon_e;
  int            total = 0;
  int            bad   = 0;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .MEM_ADDR_WIDTH(AW)) dut (
    .fetch_clk         (clk),
    .fetch_rst         (rst),
    .fetch_mem_addr    (mem_addr),
    .fetch_mem_data    (mem_data),
    .fetch_instr       (instr),
    .fetch_pc          (fpc),
    .fetch_valid       (valid),
    .fetch_ready       (ready),
    .fetch_redirect    (redirect),
    .fetch_redirect_pc (redirect_pc),
    .fetch_misalign    (misalign)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory.
  always @(posedge clk) mem_data <= mem[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem[pc[6:2]];
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of reset; returns at the start of cycle 0.
  task automatic do_reset();
    rst         = 1'b1;
    ready       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    step();
    rst = 1'b0;
  endtask

  // Monitor: every accepted instruction must be the next one expected.
  always @(negedge clk) begin
    if (valid && ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: got pc %h want nothing", fpc);
      end else begin
        mon_e = sb.pop_front();
        check("sb_pc", fpc, mon_e.pc);
        check("sb_instr", instr, mon_e.instr);
      end
    end
  end

  // Streaming from reset; ends at cycle 6 with ready dropped.
  task automatic first_scenario();
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", fpc, 32'd0);
    check("rst_misalign", {31'b0, misalign}, 32'd0);
    check("rst_mem_addr", {27'b0, mem_addr}, 32'd0);
    ready = 1'b1;
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
    step();
    check("c1_mem_addr", {27'b0, mem_addr}, 32'd1);
    check("c1_valid", {31'b0, valid}, 32'd0);
    step();
    check("c2_mem_addr", {27'b0, mem_addr}, 32'd2);
    check("c2_valid", {31'b0, valid}, 32'd1);
    step();
    check("c3_mem_addr", {27'b0, mem_addr}, 32'd3);
    repeat (3) step();
    ready = 1'b0;
  endtask

  task automatic redirect_scenario(input logic [31:0] target, input logic [31:0] first_pc,
                                   input logic exp_mis);
    ready = 1'b1;
    expect_pc(32'h0); expect_pc(32'h4);
    expect_pc(first_pc); expect_pc(first_pc + 32'd4); expect_pc(first_pc + 32'd8);
    step(); step(); step();
    redirect    = 1'b1;
    redirect_pc = target;
    check("rd_mis_before", {31'b0, misalign}, 32'd0);
    step();
    redirect = 1'b0;
    check("rd_t1_valid", {31'b0, valid}, 32'd0);
    check("rd_t1_misalign", {31'b0, misalign}, {31'b0, exp_mis});
    check("rd_t1_mem_addr", {27'b0, mem_addr}, {2'b0, first_pc[31:2]} & 32'h1F);
    step();
    check("rd_t2_valid", {31'b0, valid}, 32'd0);
    check("rd_t2_misalign", {31'b0, misalign}, 32'd0);
    step();
    check("rd_t3_pc", fpc, first_pc);
    check("rd_t3_instr", instr, 32'h0021A123);
    repeat (3) step();
    ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hC0DE_0000 + i;
    mem[0] = 32'h0001A003;
    mem[1] = 32'h0011A083;
    mem[2] = 32'h00818133;
    mem[3] = 32'h0021A123;
    rst = 1'b1; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    step();

    // Stream, fill the buffer, reset with it full, then stream again.
    do_reset();
    first_scenario();
    step();
    check("full_valid", {31'b0, valid}, 32'd1);
    check("full_pc", fpc, 32'h10);
    check("full_instr", instr, 32'hC0DE_0004);
    check("full_mem_addr", {27'b0, mem_addr}, 32'd6);
    do_reset();
    first_scenario();

    // Backpressure for 5 cycles once the first instruction is valid.
    do_reset();
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
    step(); step();
    check("st_c2_valid", {31'b0, valid}, 32'd1);
    for (int c = 3; c <= 6; c++) begin
      step();
      check("st_hold_pc", fpc, 32'h0);
      check("st_freeze_addr", {27'b0, mem_addr}, 32'd2);
    end
    step();
    ready = 1'b1;
    repeat (4) step();
    ready = 1'b0;

    // Aligned and misaligned redirects.
    do_reset();
    redirect_scenario(32'h0000_000C, 32'h0000_000C, 1'b0);
    do_reset();
    redirect_scenario(32'h0000_000E, 32'h0000_000C, 1'b1);

    // Redirect during a pop, then back-to-back redirects to 0x4 and 0x8.
    do_reset();
    ready = 1'b1;
    expect_pc(32'h0); expect_pc(32'h8); expect_pc(32'hC); expect_pc(32'h10);
    step(); step();
    redirect = 1'b1; redirect_pc = 32'h4;
    step();
    redirect_pc = 32'h8;
    check("bb_c3_valid", {31'b0, valid}, 32'd0);
    step();
    redirect = 1'b0;
    check("bb_c4_valid", {31'b0, valid}, 32'd0);
    check("bb_c4_mem_addr", {27'b0, mem_addr}, 32'd2);
    step();
    check("bb_c5_valid", {31'b0, valid}, 32'd0);
    step();
    check("bb_c6_pc", fpc, 32'h8);
    step(); step(); step();
    ready = 1'b0;

    step();
    check("sb_drain", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch unit for the RV32I core. It is the initiator side of the instruction-memory read port. It keeps the program counter, drives word addresses into the synchronous-read instruction memory, and captures the returned words. Fetched instructions are handed to decode through a 2-entry buffer with a valid/ready handshake, and a redirect input from execute handles branches and jumps.

## Interface
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset.
- MEM_ADDR_WIDTH, 5, width of the word index driven to instruction memory.

- fetch_clk  in  1  core clock; all state updates on the rising edge.
- fetch_rst  in  1  synchronous, active-high reset.
- fetch_mem_addr  out  MEM_ADDR_WIDTH  word index to memory: pc[MEM_ADDR_WIDTH+1:2], driven combinationally from the PC register.
- fetch_mem_data  in  32  memory read data; registered by memory, so it is valid the cycle after its address is presented.
- fetch_instr  out  32  instruction word at the buffer head.
- fetch_pc  out  32  byte address of fetch_instr.
- fetch_valid  out  1  buffer head holds a valid instruction.
- fetch_ready  in  1  decode accepts the head this cycle.
- fetch_redirect  in  1  one-cycle request to restart fetch at fetch_redirect_pc.
- fetch_redirect_pc  in  32  redirect target byte address.
- fetch_misalign  out  1  registered one-cycle pulse: the last redirect target had a nonzero [1:0].

## Operation
- State:
  - pc (32 b), the next address to issue;
  - inflight flag plus inflight_pc, covering the address issued last cycle;
  - 2-entry FIFO of {instr, pc} with count 0..2.
- pop = fetch_valid && fetch_ready. The head is removed at the clock edge.
- Issue rule: issue = !fetch_rst && !fetch_redirect && (count + inflight − pop) ≤ 1. This guarantees every returning word has a free FIFO slot.
- On issue: inflight ← 1, inflight_pc ← pc, pc ← pc + 4 (32-bit wrap). fetch_mem_addr wraps modulo 2^MEM_ADDR_WIDTH words.
- When no issue: inflight ← 0 and pc holds. fetch_mem_addr keeps showing pc; memory reads it regardless, but the data is ignored.
- Return: if inflight was 1 last cycle, push {fetch_mem_data, inflight_pc} this cycle. Push and pop in the same cycle are allowed, and count is unchanged.
- FIFO ordering is strict: fetch_instr and fetch_pc always come from the oldest entry.
- Redirect (fetch_redirect = 1 in cycle T):
  - FIFO is cleared at the end of T.
  - inflight ← 0, and the word returning in T+1 is discarded.
  - pc ← {fetch_redirect_pc[31:2], 2'b00}.
  - fetch_misalign ← (fetch_redirect_pc[1:0] != 0); otherwise fetch_misalign ← 0.
  - Nothing is issued in T.
  - A pop in cycle T still counts as delivered to decode.
  - Consecutive redirects: the last one wins, and each restarts the sequence.
- Reset has priority over redirect and handshake. It sets pc ← RESET_PC, clears FIFO and inflight, and sets fetch_misalign ← 0.
- Reset values of outputs:
  - fetch_valid = 0, fetch_instr = 0, fetch_pc = 0, fetch_misalign = 0.
  - fetch_mem_addr = RESET_PC[MEM_ADDR_WIDTH+1:2].
- There are no other states: the block is always fetching unless reset, redirecting, or the buffer is full.

## Timing
- First fetch after reset: cycle 0 is the first cycle with fetch_rst low.
  - Issue RESET_PC in cycle 0.
  - Data returns in cycle 1 and is pushed.
  - fetch_valid = 1 in cycle 2.
- Redirect latency: redirect in T → target issued in T+1 → data in T+2 → fetch_valid with fetch_pc = target in T+3.
- Throughput: with fetch_ready held high, one instruction per cycle (steady state count = 1, inflight = 1).
- Backpressure: with fetch_ready low, at most 2 buffered plus 0 inflight. pc and fetch_mem_addr freeze within 2 cycles, and no word is lost or duplicated.
- Releasing backpressure: restart is immediate. The pop cycle itself may issue.
- fetch_instr and fetch_pc are stable while fetch_valid = 1 and fetch_ready = 0.

## Test plan
- Reset, then ready = 1, with memory words 0..3 = 0x0001A003, 0x0011A083, 0x00818133, 0x0021A123:
  - fetch_mem_addr reads 0, 1, 2, 3 in cycles 0–3;
  - fetch_valid rises in cycle 2;
  - outputs are pc 0x0/0x4/0x8/0xC with the matching words on consecutive cycles.
- Stall: drop ready for 5 cycles once the first instruction is valid.
  - fetch_pc holds 0x0, count reaches 2, and fetch_mem_addr freezes at 2 (pc = 0x8).
  - After ready returns, the delivered sequence is 0x0, 0x4, 0x8, … with no gaps or repeats.
- Redirect to 0x0000_000C during streaming:
  - the in-flight word and buffered words are never presented;
  - 3 cycles later fetch_pc = 0xC, fetch_instr = 0x0021A123.
- Redirect to 0x0000_000E:
  - fetch_misalign pulses for exactly 1 cycle after the redirect;
  - fetch starts at 0xC.
- Redirect in the same cycle as a pop, and again in back-to-back cycles (0x4 then 0x8):
  - the popped entry counts as delivered once;
  - only the 0x8 stream appears.
- Assert fetch_rst mid-stream with the FIFO full:
  - next cycle fetch_valid = 0 and fetch_mem_addr = RESET_PC index;
  - the sequence then restarts exactly as in the first scenario.
